// File: rtl/sort_collector.sv
// Consumer end of the sorter output stream: gathers group_len beats into one
// packed word, flags any descending step inside the group, hands it downstream.
module sort_collector #(
    parameter int data_width = 8,
    parameter int group_len  = 4,
    parameter int cnt_width  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sort_val,
    input  logic [data_width-1:0]            sort_data,
    output logic                             sort_rdy,
    output logic                             pack_val,
    output logic [data_width*group_len-1:0]  pack_data,
    input  logic                             pack_rdy,
    output logic                             order_err,
    output logic [cnt_width-1:0]             grp_cnt
);

    localparam int idx_width   = (group_len > 1) ? $clog2(group_len) : 1;
    localparam int shift_width = data_width * (group_len - 1);
    localparam logic [idx_width-1:0] last_idx = idx_width'(group_len - 1);

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    state_t                  state;
    logic [idx_width-1:0]    idx;
    logic                    err_acc;
    logic [shift_width-1:0]  shift_reg;
    logic [shift_width-1:0]  shift_next;
    logic [data_width-1:0]   prev_data;
    logic                    accept;
    logic                    out_of_order;

    // Earlier beats shift down from the top, so after group_len-1 beats the
    // first element sits in the lowest slot and the newest one at the top.
    generate
        if (group_len > 2) begin : g_shift
            assign shift_next = {sort_data, shift_reg[shift_width-1:data_width]};
        end else begin : g_single
            assign shift_next = sort_data;
        end
    endgenerate

    assign prev_data    = shift_reg[shift_width-1 -: data_width];
    assign accept       = sort_val & sort_rdy;
    assign out_of_order = (idx != '0) && (sort_data < prev_data);

    // Single registered FSM; sort_rdy is a register so it stays low while rst is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            idx       <= '0;
            err_acc   <= 1'b0;
            shift_reg <= '0;
            sort_rdy  <= 1'b0;
            pack_val  <= 1'b0;
            pack_data <= '0;
            order_err <= 1'b0;
            grp_cnt   <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    sort_rdy <= 1'b1;
                    if (accept) begin
                        if (idx == last_idx) begin
                            pack_data <= {sort_data, shift_reg};
                            order_err <= err_acc | out_of_order;
                            err_acc   <= 1'b0;
                            idx       <= '0;
                            sort_rdy  <= 1'b0;
                            pack_val  <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            shift_reg <= shift_next;
                            err_acc   <= err_acc | out_of_order;
                            idx       <= idx + idx_width'(1);
                        end
                    end
                end
                HOLD: begin
                    if (pack_val && pack_rdy) begin
                        pack_val <= 1'b0;
                        sort_rdy <= 1'b1;
                        grp_cnt  <= grp_cnt + cnt_width'(1);
                        state    <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_collector.sv
// Randomised self-checking bench for sort_collector; expected words and order
// flags come from a plain array model of each group.
module tb_sort_collector;

    localparam int W  = 8;
    localparam int G  = 4;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           sort_val;
    logic [W-1:0]   sort_data;
    logic           sort_rdy;
    logic           pack_val;
    logic [W*G-1:0] pack_data;
    logic           pack_rdy;
    logic           order_err;
    logic [CW-1:0]  grp_cnt;

    int errors  = 0;
    int checks  = 0;
    int exp_cnt = 0;

    sort_collector #(.data_width(W), .group_len(G), .cnt_width(CW)) dut (
        .clk(clk), .rst(rst), .sort_val(sort_val), .sort_data(sort_data),
        .sort_rdy(sort_rdy), .pack_val(pack_val), .pack_data(pack_data),
        .pack_rdy(pack_rdy), .order_err(order_err), .grp_cnt(grp_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [W*G-1:0] model_pack(input logic [W-1:0] v [G]);
        logic [W*G-1:0] r = '0;
        for (int i = 0; i < G; i++) r[i*W +: W] = v[i];
        return r;
    endfunction

    function automatic logic model_err(input logic [W-1:0] v [G]);
        for (int i = 1; i < G; i++) if (v[i] < v[i-1]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: valid every cycle, 1: valid on even cycles only, 2: random gaps
    task automatic send_beats(input logic [W-1:0] v [G], input int mode,
                              output int cycles, output bit timeout);
        int  k = 0;
        bit  rdy;
        cycles  = 0;
        timeout = 0;
        while (k < G) begin
            if (cycles >= 200) begin
                timeout = 1;
                break;
            end
            if ((mode == 1 && cycles % 2 == 1) || (mode == 2 && $urandom_range(0, 2) == 0)) begin
                sort_val  = 1'b0;
                sort_data = (mode == 1) ? 8'hFF : W'($urandom_range(0, 255));
            end else begin
                sort_val  = 1'b1;
                sort_data = v[k];
            end
            rdy = sort_rdy;
            step();
            cycles++;
            if (sort_val && rdy) k++;
        end
        sort_val  = 1'b0;
        sort_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sort_val = 1'b0; sort_data = '0; pack_rdy = 1'b0;
        step(); step();
        checks++; if (sort_rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_sort_rdy: got %b expected 0", sort_rdy); end
        checks++; if (pack_val !== 1'b0) begin errors++; $display("[TB] FAIL reset_pack_val: got %b expected 0", pack_val); end
        checks++; if (pack_data !== '0) begin errors++; $display("[TB] FAIL reset_pack_data: got %h expected 0", pack_data); end
        checks++; if (order_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_order_err: got %b expected 0", order_err); end
        checks++; if (grp_cnt !== '0) begin errors++; $display("[TB] FAIL reset_grp_cnt: got %0d expected 0", grp_cnt); end
        rst = 1'b0;
        exp_cnt = 0;
        step(); step();
        checks++; if (sort_rdy !== 1'b1) begin errors++; $display("[TB] FAIL idle_sort_rdy: got %b expected 1", sort_rdy); end
        checks++; if (pack_val !== 1'b0) begin errors++; $display("[TB] FAIL idle_pack_val: got %b expected 0", pack_val); end
    endtask

    task automatic test_sorted();
        logic [W-1:0] v [G] = '{8'h03, 8'h07, 8'h07, 8'hF0};
        int cyc; bit to;
        pack_rdy = 1'b1;
        send_beats(v, 0, cyc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL sorted_timeout: got %b expected 0", to); end
        checks++; if (cyc != 4) begin errors++; $display("[TB] FAIL sorted_cycles: got %0d expected 4", cyc); end
        checks++; if (pack_val !== 1'b1) begin errors++; $display("[TB] FAIL sorted_pack_val: got %b expected 1", pack_val); end
        checks++; if (pack_data !== 32'hF0070703) begin errors++; $display("[TB] FAIL sorted_data: got %h expected f0070703", pack_data); end
        checks++; if (order_err !== 1'b0) begin errors++; $display("[TB] FAIL sorted_err: got %b expected 0", order_err); end
        step();
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        checks++; if (pack_val !== 1'b0) begin errors++; $display("[TB] FAIL sorted_drop: got %b expected 0", pack_val); end
        checks++; if (grp_cnt !== CW'(exp_cnt)) begin errors++; $display("[TB] FAIL sorted_cnt: got %0d expected %0d", grp_cnt, exp_cnt); end
        checks++; if (sort_rdy !== 1'b1) begin errors++; $display("[TB] FAIL sorted_rdy: got %b expected 1", sort_rdy); end
    endtask

    task automatic test_unsorted();
        logic [W-1:0] a [G] = '{8'h10, 8'h05, 8'h20, 8'h30};
        logic [W-1:0] b [G] = '{8'h01, 8'h02, 8'h03, 8'h04};
        int cyc; bit to;
        pack_rdy = 1'b1;
        send_beats(a, 0, cyc, to);
        checks++; if (pack_data !== 32'h30200510) begin errors++; $display("[TB] FAIL unsorted_data: got %h expected 30200510", pack_data); end
        checks++; if (order_err !== 1'b1) begin errors++; $display("[TB] FAIL unsorted_err: got %b expected 1", order_err); end
        step();
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        send_beats(b, 0, cyc, to);
        checks++; if (pack_data !== model_pack(b)) begin errors++; $display("[TB] FAIL resorted_data: got %h expected %h", pack_data, model_pack(b)); end
        checks++; if (order_err !== 1'b0) begin errors++; $display("[TB] FAIL resorted_err: got %b expected 0", order_err); end
        step();
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        checks++; if (grp_cnt !== CW'(exp_cnt)) begin errors++; $display("[TB] FAIL unsorted_cnt: got %0d expected %0d", grp_cnt, exp_cnt); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] v [G] = '{8'h40, 8'h30, 8'h50, 8'h60};
        logic [W-1:0] n [G] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int cyc; bit to;
        pack_rdy = 1'b0;
        send_beats(v, 0, cyc, to);
        checks++; if (pack_val !== 1'b1) begin errors++; $display("[TB] FAIL bp_pack_val: got %b expected 1", pack_val); end
        for (int i = 0; i < 5; i++) begin
            sort_val = 1'b1; sort_data = 8'hAA;
            step();
            checks++; if (pack_val !== 1'b1 || sort_rdy !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold: got val=%b rdy=%b expected val=1 rdy=0", pack_val, sort_rdy); end
            checks++; if (pack_data !== model_pack(v) || order_err !== model_err(v)) begin errors++; $display("[TB] FAIL bp_stable: got %h/%b expected %h/%b", pack_data, order_err, model_pack(v), model_err(v)); end
        end
        sort_val = 1'b0;
        pack_rdy = 1'b1;
        step();
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        checks++; if (pack_val !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got %b expected 0", pack_val); end
        checks++; if (grp_cnt !== CW'(exp_cnt)) begin errors++; $display("[TB] FAIL bp_cnt: got %0d expected %0d", grp_cnt, exp_cnt); end
        send_beats(n, 0, cyc, to);
        checks++; if (pack_data !== 32'h44332211) begin errors++; $display("[TB] FAIL bp_next_data: got %h expected 44332211", pack_data); end
        step();
        exp_cnt = (exp_cnt + 1) % (1 << CW);
    endtask

    task automatic test_gapped();
        logic [W-1:0] v [G] = '{8'h01, 8'h02, 8'h03, 8'h04};
        int cyc; bit to;
        pack_rdy = 1'b1;
        send_beats(v, 1, cyc, to);
        checks++; if (cyc != 7) begin errors++; $display("[TB] FAIL gapped_cycles: got %0d expected 7", cyc); end
        checks++; if (pack_data !== 32'h04030201) begin errors++; $display("[TB] FAIL gapped_data: got %h expected 04030201", pack_data); end
        step();
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        checks++; if (grp_cnt !== CW'(exp_cnt)) begin errors++; $display("[TB] FAIL gapped_cnt: got %0d expected %0d", grp_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] v [G] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        int cyc; bit to;
        pack_rdy = 1'b1;
        sort_val = 1'b1; sort_data = 8'h50; step();
        sort_data = 8'h40; step();
        sort_val = 1'b0; rst = 1'b1; step();
        checks++; if (pack_val !== 1'b0 || grp_cnt !== '0) begin errors++; $display("[TB] FAIL midrst_state: got val=%b cnt=%0d expected 0/0", pack_val, grp_cnt); end
        rst = 1'b0;
        exp_cnt = 0;
        send_beats(v, 0, cyc, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL midrst_timeout: got %b expected 0", to); end
        checks++; if (pack_data !== 32'h0D0C0B0A) begin errors++; $display("[TB] FAIL midrst_data: got %h expected 0d0c0b0a", pack_data); end
        checks++; if (order_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_err: got %b expected 0", order_err); end
        step();
        exp_cnt = 1;
        pack_rdy = 1'b0;
        send_beats(v, 0, cyc, to);
        rst = 1'b1; step(); rst = 1'b0;
        exp_cnt = 0;
        checks++; if (pack_val !== 1'b0 || grp_cnt !== '0) begin errors++; $display("[TB] FAIL holdrst_state: got val=%b cnt=%0d expected 0/0", pack_val, grp_cnt); end
        step();
    endtask

    task automatic test_wrap();
        logic [W-1:0] v [G];
        int cyc; bit to;
        pack_rdy = 1'b1;
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < G; i++) v[i] = W'($urandom_range(0, 255));
            send_beats(v, 0, cyc, to);
            checks++; if (pack_data !== model_pack(v)) begin errors++; $display("[TB] FAIL wrap_data: got %h expected %h", pack_data, model_pack(v)); end
            step();
        end
        exp_cnt = 1;
        checks++; if (grp_cnt !== 2'd1) begin errors++; $display("[TB] FAIL wrap_cnt: got %0d expected 1", grp_cnt); end
    endtask

    task automatic test_random();
        logic [W-1:0] v [G];
        int cyc, hold; bit to;
        for (int g = 0; g < 30; g++) begin
            v[0] = W'($urandom_range(0, 255));
            for (int i = 1; i < G; i++)
                v[i] = ($urandom_range(0, 1) == 1) ? W'($urandom_range(255, int'(v[i-1])))
                                                     : W'($urandom_range(0, 255));
            hold = $urandom_range(0, 3);
            pack_rdy = (hold == 0);
            send_beats(v, $urandom_range(0, 2), cyc, to);
            checks++; if (to !== 1'b0 || pack_val !== 1'b1) begin errors++; $display("[TB] FAIL rand_arrive: got timeout=%b val=%b expected 0/1", to, pack_val); end
            checks++; if (pack_data !== model_pack(v) || order_err !== model_err(v)) begin errors++; $display("[TB] FAIL rand_word: got %h/%b expected %h/%b", pack_data, order_err, model_pack(v), model_err(v)); end
            for (int h = 0; h < hold; h++) begin
                sort_val = $urandom_range(0, 1) == 1; sort_data = W'($urandom_range(0, 255));
                step();
                checks++; if (pack_data !== model_pack(v) || sort_rdy !== 1'b0) begin errors++; $display("[TB] FAIL rand_hold: got %h rdy=%b expected %h rdy=0", pack_data, sort_rdy, model_pack(v)); end
            end
            sort_val = 1'b0;
            pack_rdy = 1'b1;
            step();
            exp_cnt = (exp_cnt + 1) % (1 << CW);
            checks++; if (pack_val !== 1'b0 || grp_cnt !== CW'(exp_cnt)) begin errors++; $display("[TB] FAIL rand_handoff: got val=%b cnt=%0d expected 0/%0d", pack_val, grp_cnt, exp_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_sorted();
        test_unsorted();
        test_backpressure();
        test_gapped();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
